// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset/lock sequencer gating the PLL-domain system reset
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES   = 10,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // One shared phase counter; it only has to reach (largest cycle parameter - 1).
  localparam int MAX_PT = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_PT > LOCK_STABLE_CYCLES) ? MAX_PT : LOCK_STABLE_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [7:0]    retry_next;
  logic [7:0]    loss_next;
  logic          attempt_failed;

  logic          lock_meta;
  logic          locked_s;

  logic          pll_rst_d;
  logic          sys_rst_n_d;
  logic          ready_d;
  logic          fault_d;

  // Bring the asynchronous PLL lock indication into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // State, phase counter and the two bookkeeping counters.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET_PLL;
      cnt           <= '0;
      retry_cnt     <= 8'd0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      retry_cnt     <= retry_next;
      lock_loss_cnt <= loss_next;
    end
  end

  // Sequencing decisions; a software start overrides everything else in the cycle.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    retry_next     = retry_cnt;
    loss_next      = lock_loss_cnt;
    attempt_failed = 1'b0;

    if (start) begin
      state_next = S_RESET_PLL;
      cnt_next   = '0;
      retry_next = 8'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_next = S_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // A lock arriving on the final timeout cycle still counts as success.
          if (locked_s) begin
            state_next = S_STABILIZE;
            cnt_next   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            attempt_failed = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end

        S_STABILIZE: begin
          if (!locked_s) begin
            attempt_failed = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_next = S_RUN;
            cnt_next   = '0;
            retry_next = 8'd0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            if (lock_loss_cnt != 8'hff) begin
              loss_next = lock_loss_cnt + 8'd1;
            end
            state_next = S_RESET_PLL;
            cnt_next   = '0;
          end
        end

        S_FAULT: begin
          state_next = S_FAULT;
        end

        default: begin
          state_next = S_RESET_PLL;
          cnt_next   = '0;
        end
      endcase

      // Either retry with a fresh PLL reset pulse or give up until software intervenes.
      if (attempt_failed) begin
        cnt_next = '0;
        if (retry_cnt == RETRY_MAX) begin
          state_next = S_FAULT;
        end else begin
          retry_next = retry_cnt + 8'd1;
          state_next = S_RESET_PLL;
        end
      end
    end
  end

  // Decode outputs from the upcoming state so they switch together with it.
  always_comb begin
    pll_rst_d   = (state_next == S_RESET_PLL) || (state_next == S_FAULT);
    sys_rst_n_d = (state_next == S_RUN);
    ready_d     = (state_next == S_RUN);
    fault_d     = (state_next == S_FAULT);
  end

  // Registered outputs keep the reset lines glitch-free.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
      ready     <= ready_d;
      fault     <= fault_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

  localparam int P = 4;
  localparam int T = 20;
  localparam int L = 8;
  localparam int R = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  always #5 refclk = ~refclk;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES  (P),
    .LOCK_TIMEOUT      (T),
    .LOCK_STABLE_CYCLES(L),
    .MAX_RETRIES       (R)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .start        (start),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase plus edges elapsed in that phase, and a lock sample history.
  typedef enum int {M_PULSE, M_WAIT, M_STAB, M_RUN, M_FAULT} phase_t;
  phase_t m_ph;
  int     m_elapsed;
  int     m_retry;
  int     m_loss;
  bit     m_hist1;
  bit     m_hist2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_PULSE; m_elapsed = 0; m_retry = 0; m_loss = 0; m_hist1 = 0; m_hist2 = 0;
  endtask

  task automatic model_fail();
    if (m_retry == R) m_ph = M_FAULT;
    else begin m_retry++; m_ph = M_PULSE; m_elapsed = 0; end
  endtask

  task automatic model_edge(input bit st, input bit pl);
    bit seen;
    seen = m_hist2;
    m_hist2 = m_hist1;
    m_hist1 = pl;
    if (st) begin
      m_ph = M_PULSE; m_elapsed = 0; m_retry = 0;
    end else begin
      case (m_ph)
        M_PULSE: begin
          m_elapsed++;
          if (m_elapsed == P) begin m_ph = M_WAIT; m_elapsed = 0; end
        end
        M_WAIT: begin
          if (seen) begin m_ph = M_STAB; m_elapsed = 0; end
          else begin
            m_elapsed++;
            if (m_elapsed == T) model_fail();
          end
        end
        M_STAB: begin
          if (!seen) model_fail();
          else begin
            m_elapsed++;
            if (m_elapsed == L) begin m_ph = M_RUN; m_retry = 0; end
          end
        end
        M_RUN: begin
          if (!seen) begin
            if (m_loss < 255) m_loss++;
            m_ph = M_PULSE; m_elapsed = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [19:0] model_vec();
    logic in_run;
    in_run = (m_ph == M_RUN);
    return {(m_ph == M_PULSE) || (m_ph == M_FAULT), in_run, in_run, m_ph == M_FAULT,
            8'(m_retry), 8'(m_loss)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt};
  endfunction

  task automatic step();
    @(posedge refclk);
    if (rst_n) model_edge(start, pll_locked);
    #1;
    check("outputs", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic apply_reset();
    start = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return ready;
      1:       return sys_rst_n;
      default: return pll_rst;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int budget, output int n, output bit ok);
    n = 0;
    ok = 0;
    while (n < budget && !ok) begin
      step();
      n++;
      if (sig(which) == val) ok = 1;
    end
  endtask

  typedef struct {
    int lock_at;
    int exp_ready_edge;
    int exp_fault;
    int exp_retry;
    int exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int  n;
    bit  ok;
    int  first;
    int  pulses;
    int  high_cycles;
    bit  prev;
    bit  saw;

    vecs[0] = '{7, 18, 0, 0, 1};
    vecs[1] = '{0, 13, 0, 0, 1};
    vecs[2] = '{21, 32, 0, 0, 1};
    vecs[3] = '{22, 37, 0, 0, 2};
    vecs[4] = '{-1, -1, 1, 2, 3};

    for (int i = 0; i < 5; i++) begin
      pll_locked = 1'b0;
      apply_reset();
      if (vecs[i].lock_at == 0) pll_locked = 1'b1;
      first = -1;
      pulses = 0;
      prev = pll_rst;
      for (int e = 1; e <= 80; e++) begin
        step();
        if (ready && first < 0) first = e;
        if (prev && !pll_rst) pulses++;
        prev = pll_rst;
        if (e == vecs[i].lock_at) pll_locked = 1'b1;
      end
      check($sformatf("vec%0d_ready_edge", i), 32'(first), 32'(vecs[i].exp_ready_edge));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      check($sformatf("vec%0d_retry", i), 32'(retry_cnt), 32'(vecs[i].exp_retry));
      check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
    end

    check("fault_pll_rst", 32'(pll_rst), 32'd1);
    check("fault_sys_rst_n", 32'(sys_rst_n), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clears_fault", 32'(fault), 32'd0);
    check("start_clears_retry", 32'(retry_cnt), 32'd0);
    high_cycles = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (pll_rst) high_cycles++;
      else ok = 1;
    end
    check("restart_pulse_len", 32'(high_cycles), 32'(P));

    pll_locked = 1'b0;
    apply_reset();
    saw = 0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (sys_rst_n) saw = 1;
      if (e == 7) pll_locked = 1'b1;
      if (e == 14) pll_locked = 1'b0;
      if (e == 15) pll_locked = 1'b1;
    end
    check("glitch_pll_rst", 32'(pll_rst), 32'd1);
    check("glitch_retry", 32'(retry_cnt), 32'd1);
    check("glitch_no_release", 32'(saw), 32'd0);
    wait_for(0, 1'b1, 40, n, ok);
    check("glitch_relock_seen", 32'(ok), 32'd1);
    check("glitch_relock_edges", 32'(n), 32'd13);
    check("glitch_run_retry", 32'(retry_cnt), 32'd0);

    pll_locked = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_vs_loss_pll_rst", 32'(pll_rst), 32'd1);
    check("start_vs_loss_ready", 32'(ready), 32'd0);
    check("start_vs_loss_count", 32'(lock_loss_cnt), 32'd0);
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 40, n, ok);
    check("start_vs_loss_relock", 32'(ok), 32'd1);

    for (int it = 0; it < 260; it++) begin
      pll_locked = 1'b0;
      wait_for(1, 1'b0, 10, n, ok);
      check("loss_seen", 32'(ok), 32'd1);
      check("loss_latency", 32'(n), 32'd3);
      check("loss_ready_low", 32'(ready), 32'd0);
      if (it == 0) check("loss_first_count", 32'(lock_loss_cnt), 32'd1);
      pll_locked = 1'b1;
      wait_for(0, 1'b1, 40, n, ok);
      check("loss_relock", 32'(ok), 32'd1);
    end
    check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

    pll_locked = 1'b0;
    wait_for(2, 1'b1, 10, n, ok);
    check("midstab_loss_seen", 32'(ok), 32'd1);
    pll_locked = 1'b1;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      if (m_ph == M_STAB) ok = 1;
    end
    check("midstab_reached", 32'(ok), 32'd1);
    step();
    step();
    @(negedge refclk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pll_rst", 32'(pll_rst), 32'd1);
    check("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_retry", 32'(retry_cnt), 32'd0);
    check("async_loss", 32'(lock_loss_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    wait_for(0, 1'b1, 40, n, ok);
    check("async_restart_ready", 32'(ok), 32'd1);
    check("async_restart_edges", 32'(n), 32'd13);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 4) pll_locked = ~pll_locked;
      start = ($urandom_range(0, 299) == 0);
      step();
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
